// File: rtl/axi_pkg.sv
// AXI4 channel bundles, widths and arbiter phase encoding shared by the 2-master arbiter.
package axi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic [ID_W-1:0]   awid;
        logic [ADDR_W-1:0] awaddr;
        logic [7:0]        awlen;
        logic [2:0]        awsize;
        logic [1:0]        awburst;
        logic              awvalid;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              wlast;
        logic              wvalid;
        logic              bready;
        logic [ID_W-1:0]   arid;
        logic [ADDR_W-1:0] araddr;
        logic [7:0]        arlen;
        logic [2:0]        arsize;
        logic [1:0]        arburst;
        logic              arvalid;
        logic              rready;
    } axi_req_t;

    typedef struct packed {
        logic              awready;
        logic              wready;
        logic [ID_W-1:0]   bid;
        logic [1:0]        bresp;
        logic              bvalid;
        logic              arready;
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              rlast;
        logic              rvalid;
    } axi_rsp_t;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WRESP
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester winner select: sole requester wins, ties go to the RR pointer or the fixed master.
module rr_arb2 #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter bit PRIO_MASTER = 1'b1
) (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       valid,
    output logic       winner
);

    // Resolve the winner purely from the current requests and the tie-break source
    always_comb begin
        valid  = |req;
        winner = PRIO_MASTER;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ROUND_ROBIN ? ptr : PRIO_MASTER;
            default: winner = PRIO_MASTER;
        endcase
    end

endmodule

// File: rtl/axi_arbiter_2m1s.sv
// Two-master / one-slave AXI4 arbiter: one transaction in flight, re-arbitrates after each completes.
module axi_arbiter_2m1s
    import axi_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter bit PRIO_MASTER = 1'b1
) (
    input  logic     clock,
    input  logic     reset,
    input  axi_req_t m0_req,
    output axi_rsp_t m0_rsp,
    input  axi_req_t m1_req,
    output axi_rsp_t m1_rsp,
    output axi_req_t s_req,
    input  axi_rsp_t s_rsp
);

    arb_state_e state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [1:0] req_vec;
    logic       arb_valid;
    logic       arb_winner;
    logic       winner_ar;
    axi_req_t   gnt_req;
    axi_rsp_t   gnt_rsp;
    logic       ar_hs, r_last_hs, aw_hs, w_hs, b_hs;

    assign req_vec[0] = m0_req.arvalid | (m0_req.awvalid & m0_req.wvalid);
    assign req_vec[1] = m1_req.arvalid | (m1_req.awvalid & m1_req.wvalid);
    assign winner_ar  = arb_winner ? m1_req.arvalid : m0_req.arvalid;

    rr_arb2 #(
        .ROUND_ROBIN(ROUND_ROBIN),
        .PRIO_MASTER(PRIO_MASTER)
    ) u_rr_arb2 (
        .req   (req_vec),
        .ptr   (rr_ptr_q),
        .valid (arb_valid),
        .winner(arb_winner)
    );

    // Route the granted master to the slave; only the channel of the current phase may handshake
    always_comb begin
        gnt_req         = gnt_q ? m1_req : m0_req;
        s_req           = gnt_req;
        s_req.awvalid   = 1'b0;
        s_req.wvalid    = 1'b0;
        s_req.bready    = 1'b0;
        s_req.arvalid   = 1'b0;
        s_req.rready    = 1'b0;
        gnt_rsp         = s_rsp;
        gnt_rsp.awready = 1'b0;
        gnt_rsp.wready  = 1'b0;
        gnt_rsp.bvalid  = 1'b0;
        gnt_rsp.arready = 1'b0;
        gnt_rsp.rvalid  = 1'b0;
        case (state_q)
            RADDR: begin
                s_req.arvalid   = gnt_req.arvalid;
                gnt_rsp.arready = s_rsp.arready;
            end
            RDATA: begin
                s_req.rready   = gnt_req.rready;
                gnt_rsp.rvalid = s_rsp.rvalid;
            end
            WADDR: begin
                s_req.awvalid   = gnt_req.awvalid & ~aw_done_q;
                gnt_rsp.awready = s_rsp.awready & ~aw_done_q;
                s_req.wvalid    = gnt_req.wvalid & ~w_done_q;
                gnt_rsp.wready  = s_rsp.wready & ~w_done_q;
            end
            WRESP: begin
                s_req.bready   = gnt_req.bready;
                gnt_rsp.bvalid = s_rsp.bvalid;
            end
            default: begin
            end
        endcase
        m0_rsp = '0;
        m1_rsp = '0;
        if (gnt_q) begin
            m1_rsp = gnt_rsp;
        end else begin
            m0_rsp = gnt_rsp;
        end
    end

    assign ar_hs     = s_req.arvalid & s_rsp.arready;
    assign r_last_hs = s_req.rready & s_rsp.rvalid & s_rsp.rlast;
    assign aw_hs     = s_req.awvalid & s_rsp.awready;
    assign w_hs      = s_req.wvalid & s_rsp.wready;
    assign b_hs      = s_req.bready & s_rsp.bvalid;

    // Arbitrate in IDLE, then walk the granted transaction through its phases back to IDLE
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_winner;
                    state_d = winner_ar ? RADDR : WADDR;
                end
            end
            RADDR: begin
                if (ar_hs) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (r_last_hs) begin
                    state_d = IDLE;
                    if (ROUND_ROBIN) begin
                        rr_ptr_d = ~gnt_q;
                    end
                end
            end
            WADDR: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d   = WRESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WRESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                    if (ROUND_ROBIN) begin
                        rr_ptr_d = ~gnt_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register arbiter state; reset abandons any transaction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            rr_ptr_q  <= PRIO_MASTER;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule
